excp_timer_ctrl: RTL and testbench
==================================

EXCP_TIMER_CTRL -- requirements
Module: excp_timer_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 csr_re  in  1  read strobe from write-back stage; csr_rvalue is valid regardless of this strobe.
REQ-004 csr_num  in  14  CSR address for read and write.
REQ-005 csr_we  in  1  CSR write strobe from write-back stage.
REQ-006 csr_wmask  in  32  per-bit write mask.
REQ-007 csr_wvalue  in  32  write data.
REQ-008 wb_ex  in  1  exception commit, one cycle.
REQ-009 ertn_flush  in  1  ertn commit, one cycle.
REQ-010 wb_pc  in  32  PC of the committing instruction.
REQ-011 wb_ecode/wb_esubcode  in  6/9  exception cause.
REQ-012 hw_int_in  in  8  level hardware interrupts.
REQ-013 ipi_int_in  in  1  level inter-processor interrupt.
REQ-014 csr_rvalue  out  32  combinational read data for csr_num.
REQ-015 has_int  out  1  interrupt pending and enabled.
REQ-016 ex_entry/ertn_entry  out  32/32  redirect targets: EENTRY and ERA.

Function
REQ-017 CSR map: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, EENTRY 0xC, TID 0x40, TCFG 0x41, TVAL 0x42 (read-only), TICLR 0x44 (reads 0); unmapped addresses read 0 and ignore writes.
REQ-018 Write: new = (old & ~wmask) | (wvalue & wmask), restricted to writable fields; the write takes effect at the next edge, and a same-cycle read returns the old value.
REQ-019 Writable fields: CRMD PLV[1:0], IE[2]; PRMD PPLV[1:0], PIE[2]; ECFG LIE[9:0], LIE[12:11]; ESTAT IS[1:0] only; ERA all bits; EENTRY [31:6]; TID all bits; TCFG En[0], Periodic[1], InitVal[31:2].
REQ-020 Each cycle, ESTAT.IS[9:2] <= hw_int_in and ESTAT.IS[12] <= ipi_int_in.
REQ-021 On wb_ex:
  - PRMD.PPLV/PIE <= CRMD.PLV/IE.
  - CRMD.PLV <= 0 and CRMD.IE <= 0.
  - ESTAT.Ecode[21:16] <= wb_ecode and ESTAT.EsubCode[30:22] <= wb_esubcode.
  - ERA <= wb_pc.
  - Any csr_we in the same cycle is discarded.
REQ-022 On ertn_flush: CRMD.PLV/IE <= PRMD.PPLV/PIE; if wb_ex is also asserted, wb_ex wins and the ertn is ignored.
REQ-023 has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).
REQ-024 Timer state machine:
  - States: IDLE (TCFG.En=0) and COUNT (TCFG.En=1).
  - A TCFG write with En=1 loads TVAL <= {InitVal, 2'b00} and enters COUNT.
  - A TCFG write with En=0 enters IDLE and freezes TVAL.
REQ-025 In COUNT with TVAL != 0: TVAL decrements by 1 each cycle.
REQ-026 In COUNT with TVAL == 0:
  - ESTAT.IS[11] <= 1.
  - If Periodic=1: TVAL <= {InitVal, 2'b00} and the timer stays in COUNT.
  - If Periodic=0: TCFG.En <= 0, the timer enters IDLE, and TVAL stays 0.
REQ-027 A TCFG write with En=1 in the same cycle as expiry: the write wins (reload, stay in COUNT), and IS[11] is still set.
REQ-028 TICLR write with wvalue[0]&wmask[0] clears ESTAT.IS[11]; if expiry occurs in the same cycle, the set wins.
REQ-029 IS[11] is modified only by REQ-026 and REQ-028; CSR writes to ESTAT never change IS[11].
REQ-030 ex_entry = EENTRY and ertn_entry = ERA, both combinational.

Reset
REQ-031 While reset=1:
  - CRMD = 0x00000008 (PLV=0, IE=0, DA=1).
  - All other registers, including TVAL, are 0.
  - Timer is in IDLE.
  - has_int = 0.
REQ-032 Reset asserted mid-count aborts the timer at once; no IS[11] set is retained.

Verification
REQ-033 Reset mid-count: assert reset while TVAL=5 -> TVAL=0, CRMD=0x8, has_int=0.
REQ-034 One-shot timer:
  - Stimulus: write TCFG=0x11 (InitVal=4, Periodic=0, En=1).
  - TVAL reads 16, 15, ... and reaches 0 after 16 cycles.
  - On the next edge, IS[11]=1 and En=0.
  - TVAL stays 0 afterwards.
REQ-035 Periodic timer:
  - Stimulus: write TCFG=0x7 (InitVal=1, Periodic=1, En=1).
  - Expected: IS[11] set every 5 cycles and TVAL reload value 4.
  - A TICLR write in the expiry cycle leaves IS[11]=1.
REQ-036 Exception commit:
  - Stimulus: CRMD=0x7, then wb_ex with wb_pc=0x1C000100, ecode=0xB, plus a simultaneous csr_we to ERA.
  - Expected: PRMD=0x7, CRMD=0x8, ERA=0x1C000100, ESTAT[21:16]=0xB.
  - ertn_flush one cycle later -> CRMD=0xF.
REQ-037 Interrupt enable:
  - Stimulus: ECFG.LIE=0x800, CRMD.IE=1, timer expiry -> has_int=1.
  - Clear IE -> has_int=0 and IS[11] is unchanged.
REQ-038 Masked writes:
  - Stimulus: ESTAT write with wvalue=0xFFFFFFFF, wmask=0xFFFFFFFF.
  - Expected: only IS[1:0] change.
  - Read of CSR 0x3 returns 0.

Source files
------------

// File: rtl/excp_timer_ctrl.sv
// excp_timer_ctrl: exception/interrupt CSR block with a countdown timer.
// Ports:
//   clk, reset                   - single clock, asynchronous active-high reset
//   csr_re/csr_num/csr_we/...    - CSR read/write port (read data is combinational)
//   wb_ex/ertn_flush/wb_pc/...   - exception and ertn commit from write-back
//   hw_int_in/ipi_int_in         - level interrupt sources sampled into ESTAT.IS
//   csr_rvalue                   - read data for csr_num
//   has_int                      - enabled interrupt pending
//   ex_entry/ertn_entry          - redirect targets (EENTRY, ERA)
module excp_timer_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] csr_rvalue,
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NUM_W = 14;
  localparam int unsigned IS_W  = 13;

  localparam logic [NUM_W-1:0] CSR_CRMD   = NUM_W'(14'h00);
  localparam logic [NUM_W-1:0] CSR_PRMD   = NUM_W'(14'h01);
  localparam logic [NUM_W-1:0] CSR_ECFG   = NUM_W'(14'h04);
  localparam logic [NUM_W-1:0] CSR_ESTAT  = NUM_W'(14'h05);
  localparam logic [NUM_W-1:0] CSR_ERA    = NUM_W'(14'h06);
  localparam logic [NUM_W-1:0] CSR_EENTRY = NUM_W'(14'h0C);
  localparam logic [NUM_W-1:0] CSR_TID    = NUM_W'(14'h40);
  localparam logic [NUM_W-1:0] CSR_TCFG   = NUM_W'(14'h41);
  localparam logic [NUM_W-1:0] CSR_TVAL   = NUM_W'(14'h42);
  localparam logic [NUM_W-1:0] CSR_TICLR  = NUM_W'(14'h44);

  // LIE[10] is reserved and never stored
  localparam logic [IS_W-1:0] LIE_MASK = IS_W'(13'h1BFF);

  typedef enum logic {T_IDLE = 1'b0, T_COUNT = 1'b1} tstate_e;

  tstate_e          state_q, state_d;
  logic [1:0]       crmd_plv_q, crmd_plv_d;
  logic             crmd_ie_q, crmd_ie_d;
  logic [1:0]       prmd_pplv_q, prmd_pplv_d;
  logic             prmd_pie_q, prmd_pie_d;
  logic [IS_W-1:0]  ecfg_lie_q, ecfg_lie_d;
  logic [IS_W-1:0]  estat_is_q, estat_is_d;
  logic [5:0]       estat_ecode_q, estat_ecode_d;
  logic [8:0]       estat_esub_q, estat_esub_d;
  logic [XLEN-1:0]  era_q, era_d;
  logic [25:0]      eentry_q, eentry_d;
  logic [XLEN-1:0]  tid_q, tid_d;
  logic [XLEN-1:0]  tcfg_q, tcfg_d;
  logic [XLEN-1:0]  tval_q, tval_d;

  logic [XLEN-1:0]  wr_data;
  logic             we_ok;
  logic             tcfg_wr;
  logic             ticlr_wr;
  logic             expire;
  logic             unused_re;

  // Read strobe is informational only; read data is always driven
  assign unused_re = csr_re;

  // Combinational CSR read mux; unmapped addresses and TICLR read 0
  always_comb begin
    csr_rvalue = '0;
    case (csr_num)
      CSR_CRMD:   csr_rvalue = {28'd0, 1'b1, crmd_ie_q, crmd_plv_q};
      CSR_PRMD:   csr_rvalue = {29'd0, prmd_pie_q, prmd_pplv_q};
      CSR_ECFG:   csr_rvalue = {19'd0, ecfg_lie_q};
      CSR_ESTAT:  csr_rvalue = {1'b0, estat_esub_q, estat_ecode_q, 3'd0, estat_is_q};
      CSR_ERA:    csr_rvalue = era_q;
      CSR_EENTRY: csr_rvalue = {eentry_q, 6'd0};
      CSR_TID:    csr_rvalue = tid_q;
      CSR_TCFG:   csr_rvalue = tcfg_q;
      CSR_TVAL:   csr_rvalue = tval_q;
      default:    csr_rvalue = '0;
    endcase
  end

  // Masked merge against the current read value; field restriction happens per register
  assign wr_data  = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);
  assign we_ok    = csr_we & ~wb_ex;
  assign tcfg_wr  = we_ok && (csr_num == CSR_TCFG);
  assign ticlr_wr = we_ok && (csr_num == CSR_TICLR) && wr_data[0];
  assign expire   = (state_q == T_COUNT) && (tval_q == '0);

  assign has_int    = crmd_ie_q & (|(estat_is_q & ecfg_lie_q));
  assign ex_entry   = {eentry_q, 6'd0};
  assign ertn_entry = era_q;

  // State and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= T_IDLE;
      crmd_plv_q    <= '0;
      crmd_ie_q     <= 1'b0;
      prmd_pplv_q   <= '0;
      prmd_pie_q    <= 1'b0;
      ecfg_lie_q    <= '0;
      estat_is_q    <= '0;
      estat_ecode_q <= '0;
      estat_esub_q  <= '0;
      era_q         <= '0;
      eentry_q      <= '0;
      tid_q         <= '0;
      tcfg_q        <= '0;
      tval_q        <= '0;
    end else begin
      state_q       <= state_d;
      crmd_plv_q    <= crmd_plv_d;
      crmd_ie_q     <= crmd_ie_d;
      prmd_pplv_q   <= prmd_pplv_d;
      prmd_pie_q    <= prmd_pie_d;
      ecfg_lie_q    <= ecfg_lie_d;
      estat_is_q    <= estat_is_d;
      estat_ecode_q <= estat_ecode_d;
      estat_esub_q  <= estat_esub_d;
      era_q         <= era_d;
      eentry_q      <= eentry_d;
      tid_q         <= tid_d;
      tcfg_q        <= tcfg_d;
      tval_q        <= tval_d;
    end
  end

  // Timer next state: a TCFG write always overrides expiry behaviour
  always_comb begin
    state_d = state_q;
    case (state_q)
      T_IDLE: begin
        if (tcfg_wr && wr_data[0]) state_d = T_COUNT;
      end
      T_COUNT: begin
        if (tcfg_wr)                        state_d = wr_data[0] ? T_COUNT : T_IDLE;
        else if (expire && !tcfg_q[1])      state_d = T_IDLE;
      end
      default: state_d = T_IDLE;
    endcase
  end

  // Timer datapath: TCFG/TVAL updates and the IS[11] set/clear
  always_comb begin
    tcfg_d        = tcfg_q;
    tval_d        = tval_q;
    estat_is_d    = estat_is_q;
    estat_is_d[9:2] = hw_int_in;
    estat_is_d[10]  = 1'b0;
    estat_is_d[12]  = ipi_int_in;
    if (we_ok && (csr_num == CSR_ESTAT)) estat_is_d[1:0] = wr_data[1:0];
    if (tcfg_wr) begin
      tcfg_d = wr_data;
      if (wr_data[0]) tval_d = {wr_data[31:2], 2'b00};
    end else if (expire) begin
      if (tcfg_q[1]) tval_d = {tcfg_q[31:2], 2'b00};
      else           tcfg_d[0] = 1'b0;
    end else if (state_q == T_COUNT) begin
      tval_d = tval_q - XLEN'(1);
    end
    // Expiry set takes priority over a same-cycle clear
    if (ticlr_wr) estat_is_d[11] = 1'b0;
    if (expire)   estat_is_d[11] = 1'b1;
  end

  // Exception/ertn state and plain CSR writes; commit discards any CSR write
  always_comb begin
    crmd_plv_d    = crmd_plv_q;
    crmd_ie_d     = crmd_ie_q;
    prmd_pplv_d   = prmd_pplv_q;
    prmd_pie_d    = prmd_pie_q;
    ecfg_lie_d    = ecfg_lie_q;
    estat_ecode_d = estat_ecode_q;
    estat_esub_d  = estat_esub_q;
    era_d         = era_q;
    eentry_d      = eentry_q;
    tid_d         = tid_q;
    if (we_ok) begin
      case (csr_num)
        CSR_CRMD: begin
          crmd_plv_d = wr_data[1:0];
          crmd_ie_d  = wr_data[2];
        end
        CSR_PRMD: begin
          prmd_pplv_d = wr_data[1:0];
          prmd_pie_d  = wr_data[2];
        end
        CSR_ECFG:   ecfg_lie_d = wr_data[IS_W-1:0] & LIE_MASK;
        CSR_ERA:    era_d      = wr_data;
        CSR_EENTRY: eentry_d   = wr_data[31:6];
        CSR_TID:    tid_d      = wr_data;
        default: ;
      endcase
    end
    if (wb_ex) begin
      prmd_pplv_d   = crmd_plv_q;
      prmd_pie_d    = crmd_ie_q;
      crmd_plv_d    = 2'd0;
      crmd_ie_d     = 1'b0;
      estat_ecode_d = wb_ecode;
      estat_esub_d  = wb_esubcode;
      era_d         = wb_pc;
    end else if (ertn_flush) begin
      crmd_plv_d = prmd_pplv_q;
      crmd_ie_d  = prmd_pie_q;
    end
  end

endmodule

// File: tb/tb_excp_timer_ctrl.sv
// Directed self-checking bench for excp_timer_ctrl.
module tb_excp_timer_ctrl;

  localparam logic [13:0] A_CRMD   = 14'h00;
  localparam logic [13:0] A_PRMD   = 14'h01;
  localparam logic [13:0] A_UNMAP  = 14'h03;
  localparam logic [13:0] A_ECFG   = 14'h04;
  localparam logic [13:0] A_ESTAT  = 14'h05;
  localparam logic [13:0] A_ERA    = 14'h06;
  localparam logic [13:0] A_EENTRY = 14'h0C;
  localparam logic [13:0] A_TID    = 14'h40;
  localparam logic [13:0] A_TCFG   = 14'h41;
  localparam logic [13:0] A_TVAL   = 14'h42;
  localparam logic [13:0] A_TICLR  = 14'h44;

  logic        clk;
  logic        reset;
  logic        csr_re;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic        ertn_flush;
  logic [31:0] wb_pc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] csr_rvalue;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;

  int n_cmp = 0;
  int n_err = 0;

  excp_timer_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .csr_re      (csr_re),
    .csr_num     (csr_num),
    .csr_we      (csr_we),
    .csr_wmask   (csr_wmask),
    .csr_wvalue  (csr_wvalue),
    .wb_ex       (wb_ex),
    .ertn_flush  (ertn_flush),
    .wb_pc       (wb_pc),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .hw_int_in   (hw_int_in),
    .ipi_int_in  (ipi_int_in),
    .csr_rvalue  (csr_rvalue),
    .has_int     (has_int),
    .ex_entry    (ex_entry),
    .ertn_entry  (ertn_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [13:0] num, input logic [31:0] exp);
    csr_num = num;
    #1;
    chk(tag, csr_rvalue, exp);
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] val, input logic [31:0] msk);
    csr_num    = num;
    csr_wvalue = val;
    csr_wmask  = msk;
    csr_we     = 1'b1;
    cyc();
    csr_we     = 1'b0;
    csr_wvalue = '0;
    csr_wmask  = '0;
  endtask

  initial begin
    reset = 1'b1; csr_re = 1'b1; csr_num = '0; csr_we = 1'b0;
    csr_wmask = '0; csr_wvalue = '0; wb_ex = 1'b0; ertn_flush = 1'b0;
    wb_pc = '0; wb_ecode = '0; wb_esubcode = '0; hw_int_in = '0; ipi_int_in = 1'b0;

    // Reset state
    repeat (2) cyc();
    rd("rst_crmd", A_CRMD, 32'h8);
    rd("rst_prmd", A_PRMD, 32'h0);
    rd("rst_estat", A_ESTAT, 32'h0);
    rd("rst_tval", A_TVAL, 32'h0);
    chk("rst_has_int", {31'd0, has_int}, 32'h0);
    cyc();
    rd("rst_tcfg", A_TCFG, 32'h0);
    rd("rst_era", A_ERA, 32'h0);
    rd("rst_ecfg", A_ECFG, 32'h0);
    reset = 1'b0;
    cyc();

    // Masked writes, same-cycle read returns old value
    csr_num = A_ESTAT; csr_wvalue = 32'hFFFF_FFFF; csr_wmask = 32'hFFFF_FFFF; csr_we = 1'b1;
    #1 chk("estat_old_in_wr_cycle", csr_rvalue, 32'h0);
    cyc();
    csr_we = 1'b0; csr_wvalue = '0; csr_wmask = '0;
    rd("estat_all_ones", A_ESTAT, 32'h3);
    rd("unmapped_rd", A_UNMAP, 32'h0);
    wr(A_UNMAP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd("unmapped_after_wr", A_UNMAP, 32'h0);
    wr(A_ESTAT, 32'h0, 32'h3);
    rd("estat_is_clr", A_ESTAT, 32'h0);
    hw_int_in = 8'hA5; ipi_int_in = 1'b1;
    cyc();
    rd("estat_hw_ipi", A_ESTAT, 32'h1294);
    hw_int_in = 8'h00; ipi_int_in = 1'b0;
    cyc();
    rd("estat_hw_off", A_ESTAT, 32'h0);
    wr(A_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd("ecfg_fields", A_ECFG, 32'h1BFF);
    wr(A_ECFG, 32'h0, 32'hFFFF_FFFF);
    wr(A_TICLR, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd("ticlr_reads_0", A_TICLR, 32'h0);
    wr(A_TID, 32'hCAFE_F00D, 32'hFFFF_0000);
    rd("tid_masked", A_TID, 32'hCAFE_0000);
    wr(A_EENTRY, 32'h1234_5678, 32'hFFFF_FFFF);
    rd("eentry_align", A_EENTRY, 32'h1234_5640);
    chk("ex_entry", ex_entry, 32'h1234_5640);
    wr(A_CRMD, 32'hFFFF_FFFF, 32'h3);
    rd("crmd_plv_only", A_CRMD, 32'hB);
    wr(A_CRMD, 32'h7, 32'hFFFF_FFFF);
    rd("crmd_7", A_CRMD, 32'hF);

    // Exception commit with a discarded ERA write
    wb_ex = 1'b1; wb_pc = 32'h1C00_0100; wb_ecode = 6'hB; wb_esubcode = 9'h0;
    csr_num = A_ERA; csr_wvalue = 32'hDEAD_BEEF; csr_wmask = 32'hFFFF_FFFF; csr_we = 1'b1;
    cyc();
    wb_ex = 1'b0; csr_we = 1'b0; csr_wvalue = '0; csr_wmask = '0;
    rd("ex_prmd", A_PRMD, 32'h7);
    rd("ex_crmd", A_CRMD, 32'h8);
    rd("ex_era", A_ERA, 32'h1C00_0100);
    rd("ex_estat", A_ESTAT, 32'h000B_0000);
    chk("ertn_entry", ertn_entry, 32'h1C00_0100);
    ertn_flush = 1'b1;
    cyc();
    ertn_flush = 1'b0;
    rd("ertn_crmd", A_CRMD, 32'hF);

    // wb_ex and ertn together: exception wins
    wb_ex = 1'b1; ertn_flush = 1'b1; wb_pc = 32'h1C00_0200; wb_ecode = 6'h3; wb_esubcode = 9'h1;
    cyc();
    wb_ex = 1'b0; ertn_flush = 1'b0;
    rd("exertn_crmd", A_CRMD, 32'h8);
    rd("exertn_prmd", A_PRMD, 32'h7);
    rd("exertn_estat", A_ESTAT, 32'h0043_0000);
    rd("exertn_era", A_ERA, 32'h1C00_0200);
    ertn_flush = 1'b1;
    cyc();
    ertn_flush = 1'b0;
    rd("ertn2_crmd", A_CRMD, 32'hF);
    wr(A_CRMD, 32'h0, 32'hFFFF_FFFF);
    rd("crmd_cleared", A_CRMD, 32'h8);

    // One-shot timer: InitVal=4
    wr(A_TCFG, 32'h11, 32'hFFFF_FFFF);
    rd("os_tval_load", A_TVAL, 32'd16);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      rd("os_tval_count", A_TVAL, 32'(16 - k));
    end
    rd("os_is11_pre", A_ESTAT, 32'h0043_0000);
    rd("os_tcfg_pre", A_TCFG, 32'h11);
    cyc();
    rd("os_is11_set", A_ESTAT, 32'h0043_0800);
    rd("os_en_clr", A_TCFG, 32'h10);
    rd("os_tval_0", A_TVAL, 32'h0);
    cyc(); cyc();
    rd("os_tval_hold", A_TVAL, 32'h0);
    wr(A_TICLR, 32'h1, 32'h1);
    rd("ticlr_clears", A_ESTAT, 32'h0043_0000);

    // Periodic timer: InitVal=1
    wr(A_TCFG, 32'h7, 32'hFFFF_FFFF);
    rd("per_tval_load", A_TVAL, 32'd4);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      rd("per_tval_count", A_TVAL, 32'(4 - k));
    end
    rd("per_is11_pre", A_ESTAT, 32'h0043_0000);
    cyc();
    rd("per_reload", A_TVAL, 32'd4);
    rd("per_is11_set", A_ESTAT, 32'h0043_0800);
    wr(A_TICLR, 32'h1, 32'h1);
    rd("per_ticlr", A_ESTAT, 32'h0043_0000);
    rd("per_tval_3", A_TVAL, 32'd3);
    cyc(); cyc(); cyc();
    rd("per_tval_0", A_TVAL, 32'h0);
    wr(A_TICLR, 32'h1, 32'h1);
    rd("per_set_beats_clr", A_ESTAT, 32'h0043_0800);
    rd("per_reload2", A_TVAL, 32'd4);
    rd("per_tcfg", A_TCFG, 32'h7);
    wr(A_TICLR, 32'h1, 32'h1);
    rd("per_ticlr2", A_ESTAT, 32'h0043_0000);
    cyc(); cyc(); cyc();
    rd("per_tval_0b", A_TVAL, 32'h0);
    // TCFG write in the expiry cycle: write reloads, IS[11] still set
    wr(A_TCFG, 32'h9, 32'hFFFF_FFFF);
    rd("wr_exp_tval", A_TVAL, 32'd8);
    rd("wr_exp_is11", A_ESTAT, 32'h0043_0800);
    rd("wr_exp_tcfg", A_TCFG, 32'h9);

    // Interrupt enable
    wr(A_TICLR, 32'h1, 32'h1);
    rd("int_ticlr", A_ESTAT, 32'h0043_0000);
    wr(A_ECFG, 32'h800, 32'hFFFF_FFFF);
    wr(A_CRMD, 32'h4, 32'h4);
    rd("int_crmd_ie", A_CRMD, 32'hC);
    chk("int_none", {31'd0, has_int}, 32'h0);
    rd("int_tval_5", A_TVAL, 32'd5);
    repeat (5) cyc();
    chk("int_pre_exp", {31'd0, has_int}, 32'h0);
    cyc();
    chk("int_on_exp", {31'd0, has_int}, 32'h1);
    rd("int_estat", A_ESTAT, 32'h0043_0800);
    rd("int_tcfg_en0", A_TCFG, 32'h8);
    wr(A_CRMD, 32'h0, 32'h4);
    chk("int_ie_off", {31'd0, has_int}, 32'h0);
    rd("int_is11_kept", A_ESTAT, 32'h0043_0800);

    // Reset mid-count
    wr(A_CRMD, 32'h4, 32'h4);
    chk("pre_rst_int", {31'd0, has_int}, 32'h1);
    wr(A_TCFG, 32'h9, 32'hFFFF_FFFF);
    cyc(); cyc(); cyc();
    rd("pre_rst_tval", A_TVAL, 32'd5);
    reset = 1'b1;
    #1;
    rd("mid_rst_tval", A_TVAL, 32'h0);
    rd("mid_rst_crmd", A_CRMD, 32'h8);
    chk("mid_rst_int", {31'd0, has_int}, 32'h0);
    rd("mid_rst_estat", A_ESTAT, 32'h0);
    rd("mid_rst_tcfg", A_TCFG, 32'h0);
    cyc(); cyc();
    reset = 1'b0;
    repeat (3) cyc();
    rd("post_rst_tval", A_TVAL, 32'h0);
    rd("post_rst_estat", A_ESTAT, 32'h0);
    chk("post_rst_int", {31'd0, has_int}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
